// File: rtl/nmc_bank_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nmc_bank_initiator: WRITE/READ/CM burst sequencer for the NMC bank port,  |
// | results buffered in a small FIFO. Option: NMC_PERF_CNT_EN (perf_stall).   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module nmc_bank_initiator #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 1024,
  parameter int RES_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_vld,
  output logic                cmd_rdy,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic [DATA_W-1:0]   src_d,
  input  logic                src_vld,
  output logic                src_rdy,
  output logic [DATA_W-1:0]   res_d,
  output logic                res_vld,
  input  logic                res_rdy,
  output logic                done,
  output logic [ADDR_W-1:0]   nmc_addr,
  output logic                nmc_we,
  output logic                nmc_cme,
  output logic [DATA_W-1:0]   nmc_d,
  output logic [DATA_W-1:0]   nmc_cmIn,
  output logic                nmc_cmIn_vld,
  input  logic                nmc_cmIn_rdy,
  input  logic [DATA_W-1:0]   nmc_q,
  input  logic [DATA_W-1:0]   nmc_cmOut,
  input  logic                nmc_cmOut_vld,
  output logic                nmc_cmOut_rdy
`ifdef NMC_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall
`endif
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int PTR_W = $clog2(RES_DEPTH);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_write = 3'd1;
  localparam logic [2:0] c_read  = 3'd2;
  localparam logic [2:0] c_cm    = 3'd3;
  localparam logic [2:0] c_drain = 3'd4;

  localparam logic [1:0] c_op_write = 2'd0;
  localparam logic [1:0] c_op_read  = 2'd1;
  localparam logic [1:0] c_op_cm    = 2'd2;
  localparam logic [1:0] c_op_rsvd  = 2'd3;

  localparam logic [PTR_W+1:0] c_depth = (PTR_W+2)'(RES_DEPTH);

  logic [2:0]        r_state;
  logic              r_live;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_iss;
  logic [CNT_W-1:0]  r_ret;
  logic              r_rd_pend;
  logic              r_done;

  logic [DATA_W-1:0] r_mem [RES_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_iss_more;
  logic              w_last_iss;
  logic              w_wr_beat;
  logic              w_rd_issue;
  logic              w_cm_beat;
  logic              w_iss_inc;
  logic              w_push_cm;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_push_d;
  logic [PTR_W+1:0]  w_fill;
  logic [CNT_W-1:0]  w_ret_next;

  assign w_full     = (r_count == (PTR_W+1)'(RES_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_accept   = cmd_vld & cmd_rdy;
  assign w_iss_more = (r_iss < r_len);
  assign w_last_iss = ((r_iss + CNT_W'(1)) == r_len);

  // A read in flight already owns a FIFO slot, so it counts against space.
  assign w_fill     = {1'b0, r_count} + {{(PTR_W+1){1'b0}}, r_rd_pend};
  assign w_wr_beat  = (r_state == c_write) & src_vld;
  assign w_rd_issue = (r_state == c_read) & w_iss_more & (w_fill < c_depth);
  assign w_cm_beat  = (r_state == c_cm) & w_iss_more & src_vld & nmc_cmIn_rdy;
  assign w_iss_inc  = w_wr_beat | w_rd_issue | w_cm_beat;

  assign w_push_cm  = (r_op == c_op_cm) & ((r_state == c_cm) | (r_state == c_drain))
                    & nmc_cmOut_vld & ~w_full;
  assign w_push     = r_rd_pend | w_push_cm;
  assign w_push_d   = r_rd_pend ? nmc_q : nmc_cmOut;
  assign w_pop      = ~w_empty & res_rdy;
  assign w_ret_next = r_ret + CNT_W'(w_push);

  assign cmd_rdy       = (r_state == c_idle) & r_live;
  assign src_rdy       = (r_state == c_write) | ((r_state == c_cm) & w_iss_more & nmc_cmIn_rdy);
  assign nmc_we        = w_wr_beat;
  assign nmc_cme       = (r_state == c_cm) | ((r_state == c_drain) & (r_op == c_op_cm));
  assign nmc_cmIn_vld  = (r_state == c_cm) & w_iss_more & src_vld;
  assign nmc_addr      = ((r_state == c_write) | (r_state == c_read) | (r_state == c_cm))
                       ? (r_base + r_iss[ADDR_W-1:0]) : '0;
  assign nmc_d         = (r_state == c_write) ? src_d : '0;
  assign nmc_cmIn      = (r_state == c_cm) ? src_d : '0;
  assign nmc_cmOut_rdy = ~w_full;
  assign res_vld       = ~w_empty;
  assign res_d         = r_mem[r_rd_ptr];
  assign done          = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_idle;
      r_live    <= 1'b0;
      r_op      <= c_op_write;
      r_base    <= '0;
      r_len     <= '0;
      r_iss     <= '0;
      r_ret     <= '0;
      r_rd_pend <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_live    <= 1'b1;
      r_done    <= 1'b0;
      r_rd_pend <= w_rd_issue;
      r_iss     <= r_iss + CNT_W'(w_iss_inc);
      r_ret     <= w_ret_next;
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_op   <= cmd_op;
            r_base <= cmd_addr;
            r_len  <= cmd_len;
            r_iss  <= '0;
            r_ret  <= '0;
            if ((cmd_len == '0) || (cmd_op == c_op_rsvd)) begin
              r_done <= 1'b1;
            end else begin
              case (cmd_op)
                c_op_write: r_state <= c_write;
                c_op_read:  r_state <= c_read;
                c_op_cm:    r_state <= c_cm;
                default:    r_state <= c_idle;
              endcase
            end
          end
        end
        c_write: begin
          if (w_wr_beat && w_last_iss) begin
            r_state <= c_idle;
            r_done  <= 1'b1;
          end
        end
        c_read: begin
          if (w_rd_issue && w_last_iss) r_state <= c_drain;
        end
        c_cm: begin
          if (w_cm_beat && w_last_iss) r_state <= c_drain;
        end
        c_drain: begin
          // done lines up with the last result becoming visible in the FIFO
          if (w_ret_next == r_len) begin
            r_state <= c_idle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_d;
  end

`ifdef NMC_PERF_CNT_EN
  logic [31:0] r_perf;
  logic [1:0]  w_stall_inc;
  logic [32:0] w_perf_sum;

  assign w_stall_inc = {1'b0, (r_state == c_cm) & nmc_cmIn_vld & ~nmc_cmIn_rdy}
                     + {1'b0, nmc_cmOut_vld & ~nmc_cmOut_rdy};
  assign w_perf_sum  = {1'b0, r_perf} + 33'(w_stall_inc);
  assign perf_stall  = r_perf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if (w_accept) begin
      r_perf <= '0;
    end else begin
      r_perf <= w_perf_sum[32] ? 32'hFFFF_FFFF : w_perf_sum[31:0];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_nmc_bank_initiator.sv
`default_nettype none
// Directed bench for nmc_bank_initiator with a registered read memory and a
// one-deep compute bank that back-pressures cmIn while its result is blocked.
module tb_nmc_bank_initiator;

  localparam int AW = 8;
  localparam int DW = 64;

  logic          clk;
  logic          rst_n;
  logic          cmd_vld;
  logic          cmd_rdy;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic [DW-1:0] src_d;
  logic          src_vld;
  logic          src_rdy;
  logic [DW-1:0] res_d;
  logic          res_vld;
  logic          res_rdy;
  logic          done;
  logic [AW-1:0] nmc_addr;
  logic          nmc_we;
  logic          nmc_cme;
  logic [DW-1:0] nmc_d;
  logic [DW-1:0] nmc_cmIn;
  logic          nmc_cmIn_vld;
  logic          nmc_cmIn_rdy;
  logic [DW-1:0] nmc_q;
  logic [DW-1:0] nmc_cmOut;
  logic          nmc_cmOut_vld;
  logic          nmc_cmOut_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  nmc_bank_initiator #(.ADDR_W(AW), .DATA_W(DW), .RES_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .src_d(src_d), .src_vld(src_vld), .src_rdy(src_rdy),
    .res_d(res_d), .res_vld(res_vld), .res_rdy(res_rdy), .done(done),
    .nmc_addr(nmc_addr), .nmc_we(nmc_we), .nmc_cme(nmc_cme), .nmc_d(nmc_d),
    .nmc_cmIn(nmc_cmIn), .nmc_cmIn_vld(nmc_cmIn_vld), .nmc_cmIn_rdy(nmc_cmIn_rdy),
    .nmc_q(nmc_q), .nmc_cmOut(nmc_cmOut), .nmc_cmOut_vld(nmc_cmOut_vld),
    .nmc_cmOut_rdy(nmc_cmOut_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank environment: read data one cycle after address; compute result = operand + address.
  logic          bk_pend;
  logic [DW-1:0] bk_data;
  assign nmc_cmIn_rdy  = !bk_pend || nmc_cmOut_rdy;
  assign nmc_cmOut_vld = bk_pend;
  assign nmc_cmOut     = bk_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bk_pend <= 1'b0;
      bk_data <= '0;
    end else if (nmc_cmIn_vld && nmc_cmIn_rdy) begin
      bk_pend <= 1'b1;
      bk_data <= nmc_cmIn + {56'h0, nmc_addr};
    end else if (bk_pend && nmc_cmOut_rdy) begin
      bk_pend <= 1'b0;
    end
  end

  always @(posedge clk) nmc_q <= 64'hBEEF_0000_0000_0000 | {56'h0, nmc_addr};

  initial begin
    #100000;
    $display("FAIL global_timeout: observed simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [DW-1:0] cm_op(input int k);
    return 64'hA5A5_0000_0000_0000 + 64'(k) * 64'h0000_0001_0001;
  endfunction

  function automatic logic [DW-1:0] cm_exp(input logic [AW-1:0] base, input int k);
    logic [AW-1:0] a;
    a = base + 8'(k);
    return cm_op(k) + {56'h0, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [AW:0] len);
    int w;
    cmd_vld  = 1'b1;
    cmd_op   = op;
    cmd_addr = addr;
    cmd_len  = len;
    w = 0;
    @(negedge clk);
    while (!cmd_rdy && w < 20) begin
      cyc();
      @(negedge clk);
      w++;
    end
    if (!cmd_rdy) chk("cmd_rdy_timeout", 64'(cmd_rdy), 64'h1);
    cyc();
    cmd_vld = 1'b0;
  endtask

  // CM stream with per-cycle bookkeeping; res_rdy is held low until cycle 'rel'.
  task automatic run_cm(input logic [AW-1:0] base, input int len, input int rel, input int maxc);
    int sent, rcv, dn;
    sent = 0; rcv = 0; dn = 0;
    send_cmd(2'd2, base, 9'(len));
    for (int c = 0; c < maxc; c++) begin
      src_vld = (sent < len);
      src_d   = cm_op(sent);
      res_rdy = (c >= rel);
      @(negedge clk);
      if (c == rel - 1 && rel >= 10) begin
        chk("stall_cmOut_rdy", 64'(nmc_cmOut_rdy), 64'h0);
        chk("stall_cmIn_rdy", 64'(nmc_cmIn_rdy), 64'h0);
        chk("stall_src_rdy", 64'(src_rdy), 64'h0);
        chk("stall_beats_taken", 64'(sent), 64'd5);
      end
      if (res_vld && res_rdy) begin
        chk("cm_result", res_d, cm_exp(base, rcv));
        rcv++;
      end
      if (done) dn++;
      if (src_vld && src_rdy) sent++;
      cyc();
    end
    src_vld = 1'b0;
    res_rdy = 1'b1;
    @(negedge clk);
    chk("cm_beats_sent", 64'(sent), 64'(len));
    chk("cm_results_recv", 64'(rcv), 64'(len));
    chk("cm_done_pulses", 64'(dn), 64'd1);
    chk("cm_fifo_empty", 64'(res_vld), 64'h0);
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; cmd_vld = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0;
    src_d = '0; src_vld = 1'b0; res_rdy = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_rdy", 64'(cmd_rdy), 64'h0);
    chk("rst_ctrl", 64'({src_rdy, res_vld, done, nmc_we, nmc_cme, nmc_cmIn_vld}), 64'h0);
    chk("rst_addr", 64'(nmc_addr), 64'h0);
    chk("rst_d_cmIn", nmc_d | nmc_cmIn, 64'h0);
    chk("rst_cmOut_rdy", 64'(nmc_cmOut_rdy), 64'h1);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_rdy_first_cycle", 64'(cmd_rdy), 64'h0);
    cyc();
    @(negedge clk);
    chk("cmd_rdy_idle", 64'(cmd_rdy), 64'h1);
    cyc();

    // WRITE base 0x10 len 3 with one gap cycle
    send_cmd(2'd0, 8'h10, 9'd3);
    src_vld = 1'b1; src_d = 64'hAAAA_0000_0000_000A;
    @(negedge clk);
    chk("wr_beat0", {nmc_we, src_rdy, 54'h0, nmc_addr}, {1'b1, 1'b1, 54'h0, 8'h10});
    chk("wr_d0", nmc_d, 64'hAAAA_0000_0000_000A);
    cyc(); src_vld = 1'b0;
    @(negedge clk);
    chk("wr_gap_we", 64'(nmc_we), 64'h0);
    cyc(); src_vld = 1'b1; src_d = 64'hBBBB_0000_0000_000B;
    @(negedge clk);
    chk("wr_beat1", {nmc_we, 55'h0, nmc_addr}, {1'b1, 55'h0, 8'h11});
    chk("wr_d1", nmc_d, 64'hBBBB_0000_0000_000B);
    cyc(); src_d = 64'hCCCC_0000_0000_000C;
    @(negedge clk);
    chk("wr_beat2", {nmc_we, 55'h0, nmc_addr}, {1'b1, 55'h0, 8'h12});
    chk("wr_d2", nmc_d, 64'hCCCC_0000_0000_000C);
    cyc(); src_vld = 1'b0;
    @(negedge clk);
    chk("wr_done", 64'({done, nmc_we, res_vld}), 64'b100);
    cyc();
    @(negedge clk);
    chk("wr_done_clear", 64'({done, cmd_rdy}), 64'b01);
    cyc();

    // READ base 0x10 len 3, res_rdy=1
    res_rdy = 1'b1;
    send_cmd(2'd1, 8'h10, 9'd3);
    @(negedge clk);
    chk("rd_issue0", {nmc_we, nmc_cme, 54'h0, nmc_addr}, {2'b00, 54'h0, 8'h10});
    cyc(); @(negedge clk);
    chk("rd_issue1", {res_vld, 55'h0, nmc_addr}, {1'b0, 55'h0, 8'h11});
    cyc(); @(negedge clk);
    chk("rd_issue2", 64'(nmc_addr), 64'h12);
    chk("rd_res0", {63'h0, res_vld} == 64'h1 ? res_d : 64'hX, 64'hBEEF_0000_0000_0010);
    cyc(); @(negedge clk);
    chk("rd_res1", res_d, 64'hBEEF_0000_0000_0011);
    chk("rd_no_early_done", 64'(done), 64'h0);
    cyc(); @(negedge clk);
    chk("rd_done", 64'({done, res_vld}), 64'b11);
    chk("rd_res2", res_d, 64'hBEEF_0000_0000_0012);
    cyc(); @(negedge clk);
    chk("rd_drained", 64'({done, res_vld}), 64'b00);
    cyc();

    // CM base 0xFE len 4 with address wrap
    send_cmd(2'd2, 8'hFE, 9'd4);
    src_vld = 1'b1; src_d = cm_op(0);
    @(negedge clk);
    chk("cm_beat0", {nmc_cmIn_vld, nmc_cme, src_rdy, 53'h0, nmc_addr}, {3'b111, 53'h0, 8'hFE});
    chk("cm_cmIn0", nmc_cmIn, cm_op(0));
    cyc(); src_d = cm_op(1);
    @(negedge clk);
    chk("cm_addr1", 64'(nmc_addr), 64'hFF);
    cyc(); src_d = cm_op(2);
    @(negedge clk);
    chk("cm_addr2", 64'(nmc_addr), 64'h00);
    chk("cm_res0", res_d, cm_exp(8'hFE, 0));
    cyc(); src_d = cm_op(3);
    @(negedge clk);
    chk("cm_addr3", 64'(nmc_addr), 64'h01);
    chk("cm_res1", res_d, cm_exp(8'hFE, 1));
    cyc(); src_vld = 1'b0;
    @(negedge clk);
    chk("cm_gated", 64'({nmc_cmIn_vld, src_rdy, done}), 64'b000);
    chk("cm_res2", res_d, cm_exp(8'hFE, 2));
    cyc(); @(negedge clk);
    chk("cm_done", 64'({done, res_vld}), 64'b11);
    chk("cm_res3", res_d, cm_exp(8'hFE, 3));
    cyc(); @(negedge clk);
    chk("cm_drained", 64'({done, res_vld}), 64'b00);
    cyc();

    // CM len 8 with the result FIFO blocked, then released
    run_cm(8'h40, 8, 12, 60);

    // Zero-length and reserved-op commands
    send_cmd(2'd0, 8'h55, 9'd0);
    @(negedge clk);
    chk("len0_done", 64'({done, cmd_rdy}), 64'b11);
    chk("len0_idle_bus", {nmc_we, nmc_cme, nmc_cmIn_vld, src_rdy, 52'h0, nmc_addr}, 64'h0);
    cyc(); @(negedge clk);
    chk("len0_done_once", 64'(done), 64'h0);
    cyc();
    send_cmd(2'd3, 8'h55, 9'd5);
    @(negedge clk);
    chk("op3_done", 64'({done, cmd_rdy, res_vld}), 64'b110);
    chk("op3_idle_bus", {nmc_we, nmc_cme, nmc_cmIn_vld, src_rdy, 52'h0, nmc_addr}, 64'h0);
    cyc(); @(negedge clk);
    chk("op3_done_once", 64'(done), 64'h0);
    cyc();

    // Full-space WRITE: len 256 from 0x80 visits every address once
    send_cmd(2'd0, 8'h80, 9'h100);
    for (int k = 0; k < 256; k++) begin
      src_vld = 1'b1;
      src_d   = 64'(k);
      @(negedge clk);
      chk("wr256_addr", {nmc_we, done, 54'h0, nmc_addr}, {2'b10, 54'h0, 8'(8'h80 + 8'(k))});
      cyc();
    end
    src_vld = 1'b0;
    @(negedge clk);
    chk("wr256_done", 64'({done, nmc_we}), 64'b10);
    cyc();

    // Reset in the middle of a CM burst (2 of 6 beats issued)
    res_rdy = 1'b0;
    send_cmd(2'd2, 8'h20, 9'd6);
    src_vld = 1'b1; src_d = cm_op(0);
    cyc(); src_d = cm_op(1);
    cyc(); src_vld = 1'b0;
    @(negedge clk);
    chk("midcm_before_rst", {res_vld, 55'h0, nmc_addr}, {1'b1, 55'h0, 8'h22});
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midcm_rst_ctrl", 64'({cmd_rdy, src_rdy, res_vld, done, nmc_we, nmc_cme, nmc_cmIn_vld}), 64'h0);
    chk("midcm_rst_bus", {nmc_cmOut_rdy, 55'h0, nmc_addr}, {1'b1, 63'h0});
    cyc();
    rst_n = 1'b1;
    cyc();
    run_cm(8'h20, 3, 0, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
